// File: rtl/wheel_speed_meter_pkg.sv
// Shared types and default constants for the wheel speed meter.
// The FSM tracks whether a first hall edge has been seen since reset or since the last timeout.
package wheel_speed_meter_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_PERIOD_W        = 32;
  localparam int DEF_TIMEOUT_CYCLES  = 100000000;
  localparam int DEF_DIV_SHIFT       = 3;
  localparam int DEF_MIN_DELAY       = 100000;
  localparam int DEF_MAX_DELAY       = 10000000;

endpackage

// File: rtl/wheel_speed_meter_debounce.sv
// Two-flop synchroniser followed by a counter-based debouncer.
// The output level changes only after the synced input has disagreed with it for DEBOUNCE_CYCLES cycles in a row.
module wheel_speed_meter_debounce
  import wheel_speed_meter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic [CW-1:0] cnt_r;

  // metastability synchroniser for the asynchronous raw input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // any cycle of agreement restarts the stability count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r <= 1'b0;
      cnt_r   <= '0;
    end else if (sync2_r != level_r) begin
      if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_r <= sync2_r;
        cnt_r   <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end else begin
      cnt_r <= '0;
    end
  end

  assign level = level_r;

endmodule

// File: rtl/wheel_speed_meter.sv
// Measures the interval between debounced hall edges and converts it into a clamped chaser step delay.
// It also flags a stopped wheel on timeout and debounces the mode switch.
module wheel_speed_meter
  import wheel_speed_meter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PERIOD_W        = DEF_PERIOD_W,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int DIV_SHIFT       = DEF_DIV_SHIFT,
  parameter int MIN_DELAY       = DEF_MIN_DELAY,
  parameter int MAX_DELAY       = DEF_MAX_DELAY
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hall_in,
  input  logic                switch_in,
  output logic [PERIOD_W-1:0] blink_delay,
  output logic                delay_valid,
  output logic                stopped,
  output logic                switch_db,
  output logic [15:0]         rev_count
);

  localparam logic [PERIOD_W-1:0] TIMEOUT_V = PERIOD_W'(TIMEOUT_CYCLES);
  localparam logic [PERIOD_W-1:0] MIN_V     = PERIOD_W'(MIN_DELAY);
  localparam logic [PERIOD_W-1:0] MAX_V     = PERIOD_W'(MAX_DELAY);

  // the clamp works on the full-width shifted period so long periods cannot alias into range
  function automatic logic [PERIOD_W-1:0] clamp_delay(input logic [PERIOD_W-1:0] period);
    logic [PERIOD_W-1:0] shifted;
    shifted = period >> DIV_SHIFT;
    if (shifted < MIN_V) begin
      clamp_delay = MIN_V;
    end else if (shifted > MAX_V) begin
      clamp_delay = MAX_V;
    end else begin
      clamp_delay = shifted;
    end
  endfunction

  logic                hall_db_s;
  logic                hall_db_d_r;
  logic                event_s;
  state_t              state_r;
  state_t              state_nxt;
  logic [PERIOD_W-1:0] period_cnt_r;
  logic [PERIOD_W-1:0] delay_nxt;
  logic                valid_nxt;
  logic                stopped_nxt;
  logic                rev_inc_s;

  wheel_speed_meter_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hall_db (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (hall_in),
    .level (hall_db_s)
  );

  wheel_speed_meter_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_switch_db (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (switch_in),
    .level (switch_db)
  );

  // delayed copy of the debounced hall level for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hall_db_d_r <= 1'b0;
    end else begin
      hall_db_d_r <= hall_db_s;
    end
  end

  assign event_s = hall_db_s & ~hall_db_d_r;

  // period counter: loading 1 on the event makes the count at the next event equal to the spacing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt_r <= '0;
    end else if (event_s) begin
      period_cnt_r <= PERIOD_W'(1);
    end else if (state_r == ARMED) begin
      if (period_cnt_r < TIMEOUT_V) begin
        period_cnt_r <= period_cnt_r + PERIOD_W'(1);
      end else begin
        period_cnt_r <= period_cnt_r;
      end
    end else begin
      period_cnt_r <= '0;
    end
  end

  // next-state and output decode; an event takes priority over a timeout
  always_comb begin
    state_nxt   = state_r;
    delay_nxt   = blink_delay;
    valid_nxt   = 1'b0;
    stopped_nxt = stopped;
    rev_inc_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (event_s) begin
          state_nxt   = ARMED;
          stopped_nxt = 1'b0;
          rev_inc_s   = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      ARMED: begin
        if (event_s) begin
          delay_nxt = clamp_delay(period_cnt_r);
          valid_nxt = 1'b1;
          rev_inc_s = 1'b1;
        end else if (period_cnt_r >= TIMEOUT_V) begin
          state_nxt   = IDLE;
          stopped_nxt = 1'b1;
          delay_nxt   = MAX_V;
          valid_nxt   = 1'b1;
        end else begin
          state_nxt = ARMED;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      blink_delay <= MAX_V;
      delay_valid <= 1'b0;
      stopped     <= 1'b1;
      rev_count   <= 16'd0;
    end else begin
      state_r     <= state_nxt;
      blink_delay <= delay_nxt;
      delay_valid <= valid_nxt;
      stopped     <= stopped_nxt;
      if (rev_inc_s) begin
        rev_count <= rev_count + 16'd1;
      end else begin
        rev_count <= rev_count;
      end
    end
  end

endmodule
